// File: rtl/barrett_for_2131.sv
// ---------------------------------------------------------------------------
// barrett_for_2131
//
// Pipelined Barrett reducer: dout_r = din_a mod 2131 for any 23-bit unsigned
// din_a. The result is the canonical residue in [0, 2130].
//
// Handshake: valid-only streaming, no backpressure. A beat is transferred on
// every rising edge where din_valid = 1. The matching result is presented
// with dout_valid = 1 after the third rising edge following the sampling
// edge. Output order equals input order.
//
// Ports:
//   clk        in   1   system clock, rising edge
//   rst_n      in   1   asynchronous active-low reset, clears all pipeline state
//   din_a      in  23   unsigned operand x
//   din_valid  in   1   din_a valid this cycle
//   dout_r     out 12   x mod 2131 (holds last result while dout_valid = 0)
//   dout_valid out  1   dout_r valid this cycle
//   dout_ovf   out  1   present only with BARRETT_2131_OVF_EN defined: the
//                       input was >= 2131^2, outside the classic Barrett domain
//
// Optional feature macro: BARRETT_2131_OVF_EN
//
// Pipeline:
//   s0  capture din_a / din_valid (keeps the multiplier off the input pins)
//   s1  p = x * M, full 46-bit product, M = floor(2^34 / 2131)
//   s2  q = p >> 34, r0 = x - q*2131 in [0, 4261]
//   s3  single conditional subtraction -> dout_r
// ---------------------------------------------------------------------------
module barrett_for_2131 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [22:0] din_a,
    input  logic        din_valid,
    output logic [11:0] dout_r,
    output logic        dout_valid
`ifdef BARRETT_2131_OVF_EN
    ,
    output logic        dout_ovf
`endif
);

    localparam logic [22:0] BARRETT_M = 23'd8061881;
    localparam logic [12:0] MOD_N     = 13'd2131;
`ifdef BARRETT_2131_OVF_EN
    localparam logic [22:0] N_SQUARED = 23'd4541161;
`endif

    // Stage 0: input capture
    logic [22:0] x0_q;
    logic        v0_q;

    // Stage 1: full product
    logic [45:0] p_q,  p_d;
    logic [22:0] x1_q;
    logic        v1_q;

    // Stage 2: partial remainder
    logic [11:0] q_d;
    logic [12:0] r0_q, r0_d;
    logic        v2_q;

    // Stage 3: corrected result
    logic [11:0] r_q,  r_d;
    logic        v3_q;

    always_comb begin
        p_d  = 46'(x0_q) * 46'(BARRETT_M);
        // q is at most 3936, so the top 12 bits of the quotient hold it.
        q_d  = 12'(p_q >> 34);
        // True value is in [0, 4261]; wrapping in 24 bits then keeping 13 is exact.
        r0_d = 13'(24'(x1_q) - 24'(q_d) * 24'(MOD_N));
        // q underestimates floor(x/N) by at most one, so one subtraction suffices.
        r_d  = (r0_q >= MOD_N) ? 12'(r0_q - MOD_N) : r0_q[11:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x0_q <= '0;
            v0_q <= 1'b0;
            p_q  <= '0;
            x1_q <= '0;
            v1_q <= 1'b0;
            r0_q <= '0;
            v2_q <= 1'b0;
            r_q  <= '0;
            v3_q <= 1'b0;
        end else begin
            x0_q <= din_a;
            v0_q <= din_valid;
            p_q  <= p_d;
            x1_q <= x0_q;
            v1_q <= v0_q;
            r0_q <= r0_d;
            v2_q <= v1_q;
            // Result register only loads on a valid beat so dout_r holds the
            // last real residue during gaps.
            if (v2_q) begin
                r_q <= r_d;
            end
            v3_q <= v2_q;
        end
    end

    assign dout_r     = r_q;
    assign dout_valid = v3_q;

`ifdef BARRETT_2131_OVF_EN
    // Overflow flag rides alongside valid; qualified so it is never set on a
    // bubble.
    logic ovf1_q, ovf2_q, ovf3_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf1_q <= 1'b0;
            ovf2_q <= 1'b0;
            ovf3_q <= 1'b0;
        end else begin
            ovf1_q <= v0_q && (x0_q >= N_SQUARED);
            ovf2_q <= ovf1_q;
            ovf3_q <= ovf2_q;
        end
    end

    assign dout_ovf = ovf3_q;
`endif

endmodule

// File: tb/tb_barrett_for_2131.sv
// ---------------------------------------------------------------------------
// tb_barrett_for_2131
//
// Scoreboard bench for barrett_for_2131. The driver pushes
// {expected output cycle, expected ovf, expected residue} for each accepted
// operand; the monitor pops and compares on every dout_valid.
// ---------------------------------------------------------------------------
module tb_barrett_for_2131;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst_n;
    logic [22:0] din_a;
    logic        din_valid;
    logic [11:0] dout_r;
    logic        dout_valid;
`ifdef BARRETT_2131_OVF_EN
    logic        dout_ovf;
`endif

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    barrett_for_2131 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din_a      (din_a),
        .din_valid  (din_valid),
        .dout_r     (dout_r),
        .dout_valid (dout_valid)
`ifdef BARRETT_2131_OVF_EN
        ,
        .dout_ovf   (dout_ovf)
`endif
    );

    initial begin
        #2ms;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    // ---------------- scoreboard state ----------------
    // {cycle[31:0], ovf, residue[11:0]}
    logic [44:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int n_acc    = 0;
    int n_pulse  = 0;

    task automatic check(input string name, input longint act, input longint req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic ovf_of(input logic [22:0] x);
        return (x >= 23'd4541161);
    endfunction

    // ---------------- driver ----------------
    // Inputs change 2 ns after a rising edge; the next edge samples them, and
    // the result is expected at the negedge after the third edge beyond that.
    task automatic drive(input logic [22:0] x, input logic [11:0] r, input logic v);
        @(posedge clk);
        #2;
        din_a     = x;
        din_valid = v;
        if (v) begin
            exp_q.push_back({32'(cyc + 4), ovf_of(x), r});
            n_acc++;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 12 && exp_q.size() != 0; i++) @(negedge clk);
        check("drain_queue_empty", exp_q.size(), 0);
    endtask

    // ---------------- monitor ----------------
    logic [44:0] mon_e;
    always @(negedge clk) begin
        if (dout_valid) begin
            n_pulse++;
            if (exp_q.size() == 0) begin
                check("unexpected_dout_valid", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("dout_r", dout_r, mon_e[11:0]);
                check("latency_cycle", cyc, mon_e[44:13]);
`ifdef BARRETT_2131_OVF_EN
                check("dout_ovf", dout_ovf, mon_e[12]);
`endif
            end
        end
`ifdef BARRETT_2131_OVF_EN
        else begin
            check("dout_ovf_idle", dout_ovf, 0);
        end
`endif
    end

    // ---------------- directed vectors ----------------
    logic [22:0] dir_x [12] = '{23'd2131, 23'd2132, 23'd4261, 23'd4262, 23'd8387616,
                                23'd8388607, 23'd5000, 23'd4541160, 23'd4541161,
                                23'd1, 23'd2130, 23'd0};
    logic [11:0] dir_r [12] = '{12'd0, 12'd1, 12'd2130, 12'd0, 12'd0,
                                12'd991, 12'd738, 12'd2130, 12'd0,
                                12'd1, 12'd2130, 12'd0};

    initial begin
        rst_n     = 1'b0;
        din_a     = '0;
        din_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_dout_r", dout_r, 0);
        check("reset_dout_valid", dout_valid, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Idle: nothing valid for 20 cycles
        repeat (20) begin
            @(negedge clk);
            check("idle_dout_valid", dout_valid, 0);
            check("idle_dout_r", dout_r, 0);
        end

        // Sweep 0..2130 back-to-back: residue equals x
        for (int x = 0; x <= 2130; x++) drive(23'(x), 12'(x), 1'b1);
        drive('0, '0, 1'b0);
        drain();

        // Multiples and correction edges, back-to-back
        for (int i = 0; i < 12; i++) drive(dir_x[i], dir_r[i], 1'b1);
        // Same vectors with a bubble between each
        for (int i = 0; i < 12; i++) begin
            drive(dir_x[i], dir_r[i], 1'b1);
            drive(23'd7777, '0, 1'b0);
        end
        drain();

        // Random operands with random gaps
        for (int i = 0; i < 3000; i++) begin
            logic [22:0] x;
            logic        v;
            x = 23'($urandom_range(0, 8388607));
            v = ($urandom_range(0, 3) != 0);
            drive(x, 12'(x % 23'd2131), v);
        end
        drive('0, '0, 1'b0);
        drain();

        // Reset with three operands in flight
        drive(23'd100, 12'd100, 1'b1);
        drive(23'd200, 12'd200, 1'b1);
        drive(23'd300, 12'd300, 1'b1);
        @(posedge clk);
        #2;
        din_valid = 1'b0;
        rst_n     = 1'b0;
        #1;
        check("midreset_dout_r", dout_r, 0);
        check("midreset_dout_valid", dout_valid, 0);
        exp_q.delete();
        n_acc -= 3;
        @(posedge clk);
        #2;
        rst_n     = 1'b1;
        din_a     = 23'd5000;
        din_valid = 1'b1;
        exp_q.push_back({32'(cyc + 4), 1'b0, 12'd738});
        n_acc++;
        drive('0, '0, 1'b0);
        drain();

        repeat (5) @(negedge clk);
        check("pulse_count", n_pulse, n_acc);
        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
